// File: rtl/lcd_msg_feeder.sv
// Character source for the LCD controller. It buffers incoming bytes in a FIFO,
// tracks the cursor column and sends one character per show/LCDfinish handshake.
module lcd_msg_feeder #(
  parameter int DEPTH  = 16,
  parameter int SETTLE = 4
) (
  input  logic       CLK_27,
  input  logic       RESET,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       LCDfinish,
  output logic [7:0] Lcd_data,
  output logic       show,
  output logic       mark1,
  output logic       mark2,
  output logic [4:0] fifo_count,
  output logic       overflow,
  output logic       active
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, SHOW, HOLD, DONE} state_t;

  typedef struct packed {
    logic       send;
    logic [7:0] data;
    logic       m1;
    logic       m2;
    logic [4:0] col;
  } cls_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    head;
  logic [4:0]    col;
  logic [3:0]    rdy_cnt;
  logic          qual, push, pop;
  state_t        state, state_nxt;
  cls_t          cls;

  assign head   = mem[rd_ptr];
  assign qual   = (rdy_cnt == 4'(SETTLE));
  assign pop    = (state == LOAD) && (fifo_count != 5'd0);
  // A full FIFO still takes a byte when the same cycle frees a slot.
  assign push   = rx_valid && ((fifo_count < 5'(DEPTH)) || pop);
  assign active = (state != IDLE);

  always_ff @(posedge CLK_27) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge CLK_27) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 5'd1;
        2'b01:   fifo_count <= fifo_count - 5'd1;
        default: fifo_count <= fifo_count;
      endcase
      if (rx_valid && !push) overflow <= 1'b1;
    end
  end

  // LCDfinish must stay high SETTLE cycles; short blips inside the controller's
  // own write/clear sequences never reach qual.
  always_ff @(posedge CLK_27) begin
    if (RESET)                    rdy_cnt <= '0;
    else if (!LCDfinish)          rdy_cnt <= '0;
    else if (rdy_cnt != 4'(SETTLE)) rdy_cnt <= rdy_cnt + 4'd1;
  end

  always_comb begin
    cls      = '0;
    cls.data = head;
    cls.col  = col;
    if (head >= 8'h20 && head <= 8'h7E) begin
      cls.send = 1'b1;
      cls.m1   = (col == 5'd15);
      cls.m2   = (col == 5'd31);
      cls.col  = (col == 5'd31) ? 5'd0 : col + 5'd1;
    end else if (head == 8'h0A) begin
      cls.send = 1'b1;
      if (col < 5'd16) begin
        cls.m1  = 1'b1;
        cls.col = 5'd16;
      end else begin
        cls.m2  = 1'b1;
        cls.col = 5'd0;
      end
    end else if (head == 8'h0D && col != 5'd0) begin
      cls.send = 1'b1;
      cls.data = 8'h0A;
      cls.m2   = 1'b1;
      cls.col  = 5'd0;
    end
  end

  always_ff @(posedge CLK_27) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_count != 5'd0 && qual) state_nxt = LOAD;
      LOAD:    state_nxt = (pop && cls.send) ? SHOW : IDLE;
      SHOW:    if (!LCDfinish) state_nxt = HOLD;
      HOLD:    if (qual) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Character and marks are captured once at LOAD and frozen until DONE.
  always_ff @(posedge CLK_27) begin
    if (RESET) begin
      Lcd_data <= 8'h00;
      show     <= 1'b0;
      mark1    <= 1'b0;
      mark2    <= 1'b0;
      col      <= 5'd0;
    end else begin
      show <= (state_nxt == SHOW);
      if (state == LOAD && state_nxt == SHOW) begin
        Lcd_data <= cls.data;
        mark1    <= cls.m1;
        mark2    <= cls.m2;
        col      <= cls.col;
      end else if (state == DONE) begin
        mark1 <= 1'b0;
        mark2 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_msg_feeder.sv
// Directed bench for lcd_msg_feeder: models the LCD controller handshake by hand.
module tb_lcd_msg_feeder;
  localparam int SETTLE = 4;

  logic       CLK_27 = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       LCDfinish = 1'b1;
  logic [7:0] Lcd_data;
  logic       show, mark1, mark2, overflow, active;
  logic [4:0] fifo_count;

  int   checks = 0, errors = 0, pulses = 0, p0 = 0, k = 0;
  logic show_q = 1'b0;

  lcd_msg_feeder #(.DEPTH(16), .SETTLE(SETTLE)) dut (
    .CLK_27(CLK_27), .RESET(RESET), .rx_data(rx_data), .rx_valid(rx_valid),
    .LCDfinish(LCDfinish), .Lcd_data(Lcd_data), .show(show), .mark1(mark1),
    .mark2(mark2), .fifo_count(fifo_count), .overflow(overflow), .active(active)
  );

  always #5 CLK_27 = ~CLK_27;

  always @(posedge CLK_27) begin
    show_q <= show;
    if (show && !show_q) pulses <= pulses + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK_27);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // One full controller handshake for the next character.
  task automatic serve(input logic [7:0] d, input logic m1, input logic m2);
    for (int n = 0; n < 60 && show !== 1'b1; n++) tick();
    chk("show_rise", show, 1);
    chk("data", Lcd_data, d);
    chk("mark1", mark1, m1);
    chk("mark2", mark2, m2);
    tick(2);
    chk("show_held", show, 1);
    LCDfinish = 1'b0;
    tick();
    chk("show_fall", show, 0);
    tick(5);
    chk("hold_data", Lcd_data, d);
    chk("hold_marks", {mark1, mark2}, {m1, m2});
    LCDfinish = 1'b1;
    tick(SETTLE + 6);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tick(2);
    chk("rst_data", Lcd_data, 8'h00);
    chk("rst_show", show, 0);
    chk("rst_marks", {mark1, mark2}, 2'b00);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_active", active, 0);
    chk("rst_col", dut.col, 0);
    RESET = 1'b0;
    tick(SETTLE + 2);

    // line wrap: 32 printable characters starting at column 0
    for (int i = 0; i < 32; i++) begin
      push(8'(8'h30 + i));
      serve(8'(8'h30 + i), i == 15, i == 31);
    end
    chk("wrap_col", dut.col, 0);

    // basic handshake with exact show latency
    p0 = pulses;
    push(8'h41);
    chk("lat_n0", show, 0);
    tick();
    chk("lat_n1", show, 0);
    tick();
    chk("lat_n2", show, 1);
    chk("basic_data", Lcd_data, 8'h41);
    chk("basic_marks", {mark1, mark2}, 2'b00);
    LCDfinish = 1'b0;
    tick();
    chk("basic_fall", show, 0);
    tick(39);
    chk("basic_low", show, 0);
    chk("basic_active", active, 1);
    LCDfinish = 1'b1;
    tick(20);
    chk("basic_noreraise", show, 0);
    chk("basic_pulses", pulses - p0, 1);
    chk("basic_col", dut.col, 1);
    chk("basic_count", fifo_count, 0);
    chk("basic_idle", active, 0);

    // control bytes
    p0 = pulses;
    push(8'h41); push(8'h42); push(8'h0A); push(8'h43);
    push(8'h0D); push(8'h0D); push(8'h07);
    serve(8'h41, 0, 0);
    serve(8'h42, 0, 0);
    serve(8'h0A, 1, 0);
    serve(8'h43, 0, 0);
    serve(8'h0A, 0, 1);
    tick(20);
    chk("ctl_pulses", pulses - p0, 5);
    chk("ctl_count", fifo_count, 0);
    chk("ctl_col", dut.col, 0);

    // settle filter after a mark2 character
    push(8'h0A); push(8'h0D); push(8'h41);
    serve(8'h0A, 1, 0);
    for (int n = 0; n < 60 && show !== 1'b1; n++) tick();
    chk("set_show", show, 1);
    chk("set_data", Lcd_data, 8'h0A);
    chk("set_mark2", mark2, 1);
    LCDfinish = 1'b0;
    tick(2);
    chk("set_fall", show, 0);
    LCDfinish = 1'b1;
    tick(2);
    chk("set_blip_data", Lcd_data, 8'h0A);
    chk("set_blip_mark2", mark2, 1);
    chk("set_blip_show", show, 0);
    LCDfinish = 1'b0;
    tick(30);
    chk("set_low_mark2", mark2, 1);
    chk("set_low_active", active, 1);
    LCDfinish = 1'b1;
    for (k = 0; k < 40 && show !== 1'b1; k++) tick();
    chk("set_gap_min", k >= SETTLE + 1, 1);
    chk("set_gap", k, SETTLE + 4);
    serve(8'h41, 0, 0);

    // overflow: controller busy, 18 pushes
    LCDfinish = 1'b0;
    tick(2);
    for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
    chk("ovf_full", fifo_count, 16);
    chk("ovf_clear", overflow, 0);
    push(8'h70); push(8'h71);
    chk("ovf_count", fifo_count, 16);
    chk("ovf_set", overflow, 1);
    chk("ovf_idle", active, 0);
    LCDfinish = 1'b1;
    for (int i = 0; i < 16; i++) serve(8'(8'h60 + i), i == 14, 0);
    tick(10);
    chk("ovf_drained", fifo_count, 0);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_lost", show, 0);

    // reset while in SHOW with 5 bytes queued
    push(8'h0A);
    for (int i = 0; i < 5; i++) push(8'(8'h31 + i));
    chk("rm_show", show, 1);
    chk("rm_mark2", mark2, 1);
    chk("rm_queued", fifo_count, 5);
    RESET = 1'b1;
    tick();
    chk("rm_show0", show, 0);
    chk("rm_marks0", {mark1, mark2}, 2'b00);
    chk("rm_data0", Lcd_data, 8'h00);
    chk("rm_count0", fifo_count, 0);
    chk("rm_col0", dut.col, 0);
    chk("rm_active0", active, 0);
    chk("rm_ovf0", overflow, 0);
    RESET = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_msg_feeder.md
# lcd_msg_feeder

Character source for the LCD controller. Buffers incoming ASCII bytes (e.g. from the UART receiver) in a 16-entry FIFO. Tracks the LCD cursor column and drives the controller's `show`/`LCDfinish` handshake one character at a time, raising `mark1` at end of line 1 and `mark2` at end of page/message. Sits between the byte producer and the LCD controller.

## Interface
- `DEPTH`, 16, FIFO entries; power of two.
- `SETTLE`, 4, consecutive cycles `LCDfinish` must read 1 before it counts as done/ready; range 3..15.
- `CLK_27` input 1: system clock.
- `RESET` input 1: reset, synchronous, active-high.
- `rx_data` input 8: incoming byte.
- `rx_valid` input 1: one-cycle strobe, `rx_data` valid.
- `LCDfinish` input 1: controller ready/done flag.
- `Lcd_data` output 8: character to controller.
- `show` output 1: request to controller.
- `mark1` output 1: controller must issue line-2 command (0xC0) after this character.
- `mark2` output 1: controller must clear the display after this character.
- `fifo_count` output 5: occupancy, 0..DEPTH.
- `overflow` output 1: sticky; a byte was dropped because the FIFO was full.
- `active` output 1: FSM not in IDLE.

## Operation
- **FIFO:**
  - A push on `rx_valid` is accepted if count < DEPTH, or if count == DEPTH and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set; `overflow` is cleared only by RESET.
  - Pointers wrap modulo DEPTH.
- **Ready qualification:**
  - `rdy_cnt` (4 bit) increments while `LCDfinish`=1, saturating at SETTLE, and clears to 0 when `LCDfinish`=0.
  - `qual` = (`rdy_cnt` == SETTLE).
  - Purpose: absorbs the short `LCDfinish` highs inside the controller's post-write and clear sequences, so `Lcd_data` and the marks stay stable until the controller has finished sampling them.
- **Column `col` (0..31):**
  - 0..15 is line 1; 16..31 is line 2.
- **Byte classification at pop:**
  - 0x20..0x7E (printable): send the byte. `mark1` = (col==15). `mark2` = (col==31). col ← (col==31) ? 0 : col+1.
  - 0x0A with col<16: send 0x0A with `mark1`=1; col ← 16.
  - 0x0A with col≥16: send 0x0A with `mark2`=1; col ← 0.
  - 0x0D with col≠0: send 0x0A with `mark2`=1; col ← 0.
  - 0x0D with col==0: drop.
  - Any other byte: drop (popped, nothing sent, col unchanged).
  - `mark1` and `mark2` are never both 1.
- **FSM:**
  - IDLE: if FIFO not empty and `qual` → LOAD.
  - LOAD: pop one byte and classify. Sendable → SHOW, with `Lcd_data`/marks registered this cycle. Dropped → IDLE.
  - SHOW: `show`=1. On `LCDfinish`=0 → HOLD.
  - HOLD: `show`=0, `Lcd_data`/marks held. On `qual` → DONE.
  - DONE: clear `mark1`/`mark2` → IDLE.
- **Hold rule:** `Lcd_data`, `mark1` and `mark2` do not change from entry to SHOW until DONE.
- **Reset:** RESET in any state → IDLE. Reset values:
  - `Lcd_data`=0x00, `show`=0, `mark1`=0, `mark2`=0.
  - col=0, FIFO empty, `fifo_count`=0, `overflow`=0, `active`=0, `rdy_cnt`=0.

## Timing
- Push at edge N: `fifo_count` is updated at N+1.
- Earliest `show` rise: 2 cycles after LOAD entry (LOAD, then SHOW registered).
- From an empty FIFO with `qual` already true, `show` first goes high 3 edges after `rx_valid`.
- `show` falls on the first edge after `LCDfinish` is sampled 0.
- The next LOAD cannot start earlier than SETTLE+1 cycles after `LCDfinish` returns high.
- Simultaneous push and pop: `fifo_count` is unchanged; both are honoured, including at full.
- There is no timeout. If `LCDfinish` is stuck low, the FSM stays in HOLD; if it is stuck high after SHOW, the FSM stays in SHOW.

## Test plan
- **Basic handshake:**
  - Stimulus: push "A" (0x41); model `LCDfinish` high, dropping 0 for 40 cycles after `show` and then high.
  - Required: `show` rises with `Lcd_data`=0x41 and marks 0, falls after the drop, and is not re-raised. Final col=1, `fifo_count`=0.
- **Line wrap:**
  - Stimulus: push 32 printable bytes 0x30..0x4F.
  - Required: `mark1`=1 only with 0x3F (16th byte); `mark2`=1 only with 0x4F (32nd byte); final col=0.
- **Control bytes:**
  - Stimulus: push "AB", 0x0A, "C", 0x0D, 0x0D, 0x07.
  - Required: sends 0x41, 0x42, then 0x0A with `mark1`, then 0x43, then 0x0A with `mark2`. The second 0x0D and the 0x07 are dropped; exactly 5 `show` pulses in total.
- **Settle filter:**
  - Stimulus: after a `mark2` character, model `LCDfinish` as 1 (2 cycles), 0 (30 cycles), then 1.
  - Required: `mark2` and `Lcd_data` stay stable through the 2-cycle high; the next `show` appears only ≥SETTLE+1 cycles after the final rise.
- **Overflow:**
  - Stimulus: hold `LCDfinish`=0, push 18 bytes.
  - Required: `fifo_count`=16, `overflow`=1, bytes 17–18 lost. After `LCDfinish`=1, the 16 stored bytes go out in order.
- **Reset mid-transfer:**
  - Stimulus: assert RESET while in SHOW with 5 bytes queued.
  - Required: next cycle `show`=0, marks 0, `Lcd_data`=0, `fifo_count`=0, col=0, `active`=0.
